// File: rtl/skin_segm_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : skin_segm_pkg
//  Purpose  : Shared constants for the skin-colour segmentation front end.
//             Holds the default colour component width and the index
//             encoding used to report which component won a compare.
//  Revision : 1.0  initial release
// ============================================================================
package skin_segm_pkg;

    localparam int DATA_W = 10;
    localparam int IDX_W  = 2;

    localparam logic [IDX_W-1:0] IDX_R = 2'd0;
    localparam logic [IDX_W-1:0] IDX_G = 2'd1;
    localparam logic [IDX_W-1:0] IDX_B = 2'd2;

endpackage : skin_segm_pkg
`default_nettype wire

// File: rtl/rgb_minmax3.sv
`default_nettype none
// ============================================================================
//  Module   : rgb_minmax3
//  Purpose  : Purely combinational min/max-of-three with component index.
//             A component only wins when it is strictly smaller (larger)
//             than both others; every other case falls through to b, so
//             ties always report IDX_B and the b value.
//  Ports    : r, g, b          - unsigned colour components
//             min, max         - selected minimum / maximum values
//             min_idx, max_idx - IDX_R / IDX_G / IDX_B of the selection
//  Revision : 1.0  initial release
// ============================================================================
module rgb_minmax3
    import skin_segm_pkg::*;
#(
    parameter int W = skin_segm_pkg::DATA_W
)(
    input  logic [W-1:0]     r,
    input  logic [W-1:0]     g,
    input  logic [W-1:0]     b,
    output logic [W-1:0]     min,
    output logic [W-1:0]     max,
    output logic [IDX_W-1:0] min_idx,
    output logic [IDX_W-1:0] max_idx
);

    always_comb begin
        min     = b;
        min_idx = IDX_B;
        if (r < g && r < b) begin
            min     = r;
            min_idx = IDX_R;
        end else if (g < r && g < b) begin
            min     = g;
            min_idx = IDX_G;
        end
    end

    always_comb begin
        max     = b;
        max_idx = IDX_B;
        if (r > g && r > b) begin
            max     = r;
            max_idx = IDX_R;
        end else if (g > r && g > b) begin
            max     = g;
            max_idx = IDX_G;
        end
    end

endmodule : rgb_minmax3
`default_nettype wire

// File: rtl/minmax_rr_sched.sv
`default_nettype none
// ============================================================================
//  Module   : minmax_rr_sched
//  Purpose  : Round-robin scheduler sharing one registered min/max-of-three
//             stage between NREQ pixel requesters. Accepts at most one RGB
//             triple per cycle and returns min, max, their component indices
//             and the granted requester tag one cycle after the transfer.
//  Ports    : clk, rst (sync, active-high)
//             req_valid/req_ready/req_rgb - per-requester handshake + {r,g,b}
//             out_valid/out_ready         - result handshake
//             out_min/out_max/out_min_idx/out_max_idx/out_id - result
//             out_delta - max-min, only when MINMAX_CHROMA_EN is defined
//  Options  : `define MINMAX_CHROMA_EN adds the registered out_delta output
//  Revision : 1.0  initial release
// ============================================================================
module minmax_rr_sched
    import skin_segm_pkg::*;
#(
    parameter int NREQ   = 2,
    parameter int DATA_W = skin_segm_pkg::DATA_W,
    parameter int ID_W   = 2
)(
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NREQ-1:0]          req_valid,
    output logic [NREQ-1:0]          req_ready,
    input  logic [NREQ*3*DATA_W-1:0] req_rgb,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DATA_W-1:0]        out_min,
    output logic [DATA_W-1:0]        out_max,
    output logic [IDX_W-1:0]         out_min_idx,
    output logic [IDX_W-1:0]         out_max_idx,
    output logic [ID_W-1:0]          out_id
`ifdef MINMAX_CHROMA_EN
    ,
    output logic [DATA_W-1:0]        out_delta
`endif
);

    localparam int RGB_W = 3 * DATA_W;

    logic              w_accept;
    logic              w_found;
    logic              w_xfer;
    logic [ID_W-1:0]   w_winner;
    logic [ID_W-1:0]   w_ptr_next;
    logic [ID_W-1:0]   r_rr_ptr;
    logic [RGB_W-1:0]  w_sel;
    logic [DATA_W-1:0] w_min;
    logic [DATA_W-1:0] w_max;
    logic [IDX_W-1:0]  w_min_idx;
    logic [IDX_W-1:0]  w_max_idx;

    // The output register can take a new result when it is empty or is
    // being drained this same cycle.
    assign w_accept = !out_valid || out_ready;
    assign w_xfer   = w_accept && w_found;

    // Winner = valid requester with the smallest circular distance from the
    // pointer, which is the same as scanning upward from the pointer.
    always_comb begin
        int w_dist;
        int w_best;
        w_found  = 1'b0;
        w_winner = '0;
        w_best   = NREQ;
        w_dist   = 0;
        for (int i = 0; i < NREQ; i++) begin
            w_dist = i - int'(r_rr_ptr);
            if (w_dist < 0) begin
                w_dist = w_dist + NREQ;
            end
            if (req_valid[i] && w_dist < w_best) begin
                w_best   = w_dist;
                w_winner = ID_W'(i);
                w_found  = 1'b1;
            end
        end
    end

    always_comb begin
        w_sel = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_winner == ID_W'(i)) begin
                w_sel = req_rgb[i*RGB_W +: RGB_W];
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_ready
            assign req_ready[gi] = w_xfer && (w_winner == ID_W'(gi));
        end
    endgenerate

    assign w_ptr_next = (w_winner == ID_W'(NREQ - 1)) ? '0 : w_winner + 1'b1;

    rgb_minmax3 #(
        .W       (DATA_W)
    ) u_minmax (
        .r       (w_sel[RGB_W-1 -: DATA_W]),
        .g       (w_sel[2*DATA_W-1 -: DATA_W]),
        .b       (w_sel[DATA_W-1:0]),
        .min     (w_min),
        .max     (w_max),
        .min_idx (w_min_idx),
        .max_idx (w_max_idx)
    );

    // A new transfer overwrites the register even while the old result is
    // being consumed, so back-to-back results come with no bubble. Data is
    // left in place when valid drops; only a reset clears it.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid   <= 1'b0;
            out_min     <= '0;
            out_max     <= '0;
            out_min_idx <= '0;
            out_max_idx <= '0;
            out_id      <= '0;
            r_rr_ptr    <= '0;
        end else if (w_xfer) begin
            out_valid   <= 1'b1;
            out_min     <= w_min;
            out_max     <= w_max;
            out_min_idx <= w_min_idx;
            out_max_idx <= w_max_idx;
            out_id      <= w_winner;
            r_rr_ptr    <= w_ptr_next;
        end else if (out_ready) begin
            out_valid   <= 1'b0;
        end
    end

`ifdef MINMAX_CHROMA_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            out_delta <= '0;
        end else if (w_xfer) begin
            out_delta <= w_max - w_min;
        end
    end
`endif

endmodule : minmax_rr_sched
`default_nettype wire

// File: doc/minmax_rr_sched.md
Name: minmax_rr_sched

Overview:
- Shares one registered min/max-of-three comparator stage between NREQ pixel requesters in the skin-colour segmentation front end.
- Arbitrates round-robin, accepts at most one RGB triple per cycle, and returns min, max, argmin/argmax index and requester tag.
- Sits between the per-stream pixel sources and the HSV hue/saturation stage.

Parameters:
- NREQ, 2, number of requesters; legal 2..4.
- DATA_W, 10, width of each colour component.
- ID_W, 2, requester tag width; must satisfy 2**ID_W >= NREQ.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-high.
- req_valid  in  NREQ  per-requester valid.
- req_ready  out  NREQ  per-requester accept; combinational.
- req_rgb  in  NREQ*3*DATA_W  per-requester {r,g,b}; requester i occupies bits [i*30 +: 30], with r in the MSBs.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accept.
- out_min  out  DATA_W  minimum component.
- out_max  out  DATA_W  maximum component.
- out_min_idx  out  2  argmin: 0=r, 1=g, 2=b.
- out_max_idx  out  2  argmax, same encoding.
- out_id  out  ID_W  granted requester number.

Behaviour:
- Reset (sync, rst=1 at a clk edge): out_valid=0, out_min=0, out_max=0, out_min_idx=0, out_max_idx=0, out_id=0, rr_ptr=0. A result held in the output register is discarded, not delivered.
- accept = !out_valid || out_ready.
- Arbitration:
  - Scan req_valid starting at rr_ptr, wrapping modulo NREQ; the first asserted bit wins.
  - req_ready[i]=1 only when accept=1 and i is the winner. All other req_ready bits are 0.
  - A transfer occurs when req_valid[i] && req_ready[i].
- rr_ptr update: on a transfer, rr_ptr <= (winner+1) mod NREQ. With no transfer it holds. It never advances while out_valid && !out_ready.
- Latency: the result is registered on the clk edge of the transfer, so out_valid rises the next cycle.
- Throughput: one result per cycle while out_ready=1.
- Output hold: out_valid && !out_ready holds all out_* stable, and req_ready=0.
- Simultaneous consume and accept: out_ready=1 with a new transfer in the same cycle replaces the register contents; out_valid stays 1 with no bubble.
- out_valid falls only when out_ready=1 and there is no transfer in that cycle.
- Min rule (unsigned compare):
  - r if r<g && r<b;
  - else g if g<r && g<b;
  - else b.
- Max rule: same structure using >.
- Ties resolve as follows:
  - All three equal: both indices = 2.
  - r=g<b: min idx 2, value equal to the true minimum? No — value = b, which is not the minimum. Per the rule above, min idx 2, value = b. Downstream accepts this existing convention.
  - Implement the rule exactly as stated. Verification checks the rule, not a mathematical argmin.
- Requester protocol: once req_valid is asserted, the requester holds it and its req_rgb stable until accepted. The block does not check this.
- Unused tag values (>= NREQ) are never emitted.

Optional Feature:
- Macro: MINMAX_CHROMA_EN.
- When defined:
  - Adds output out_delta, width DATA_W, equal to out_max - out_min as computed from the same selected values.
  - Registered with the other outputs, same latency, reset to 0.
- When undefined: the port and its logic are absent; all other behaviour is identical.

Decomposition:
- Package skin_segm_pkg holds DATA_W, the index width (2), and the index constants IDX_R=0, IDX_G=1, IDX_B=2.
- Sub-module rgb_minmax3 is purely combinational: inputs r, g, b; outputs min, max, min_idx, max_idx, implementing the tie rules above.
- The scheduler instantiates one rgb_minmax3 after the grant mux and owns the arbiter, pointer and output register.

Test Plan:
- Reset then idle: rst=1 for 2 cycles, then all req_valid=0 -> out_valid=0, all out_*=0, req_ready=0.
- Single request: NREQ=2, req0 rgb=(300,100,700), out_ready=1 -> next cycle out_min=100, min_idx=1, out_max=700, max_idx=2, out_id=0.
- Round-robin fairness: both requesters valid continuously, out_ready=1 -> out_id sequence 0,1,0,1, one result per cycle, with no starvation.
- Backpressure: out_ready=0 for 3 cycles while a result is held -> out_* stable, req_ready=0, rr_ptr unchanged; then out_ready=1 -> next grant goes to the pointer's requester.
- Ties: rgb=(5,5,5) -> min=max=5, both idx=2; rgb=(5,5,9) -> min=9, min_idx=2, max=9, max_idx=2.
- Reset mid-operation and chroma option: rst asserted while out_valid=1 and out_ready=0 -> out_valid=0 the next cycle and the held result is never emitted. With MINMAX_CHROMA_EN defined and rgb=(1023,0,512) -> out_delta=1023.
